// File: rtl/vga_fb_arbiter_if.sv
// vga_fb_arbiter_if: VGA read, CPU write and framebuffer RAM bus bundle.
// slave = arbiter side, master = VGA/CPU/RAM side.
interface vga_fb_arbiter_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 8
);
  logic              vga_req;
  logic [ADDR_W-1:0] vga_addr;
  logic [DATA_W-1:0] vga_data;
  logic              vga_valid;
  logic              cpu_wr_en;
  logic [ADDR_W-1:0] cpu_wr_addr;
  logic [DATA_W-1:0] cpu_wr_data;
  logic              cpu_wr_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  vga_req, vga_addr,
    input  cpu_wr_en, cpu_wr_addr, cpu_wr_data,
    input  mem_rdata,
    output vga_data, vga_valid, cpu_wr_ready,
    output mem_addr, mem_wdata, mem_we
  );

  modport master (
    output vga_req, vga_addr,
    output cpu_wr_en, cpu_wr_addr, cpu_wr_data,
    output mem_rdata,
    input  vga_data, vga_valid, cpu_wr_ready,
    input  mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: one-port framebuffer arbiter, VGA reads over FIFO'd CPU writes.
// Ports: clock, resetn (async low), io_bus (slave). Macro: FB_STARVE_GUARD_EN.
module vga_fb_arbiter #(
  parameter int ADDR_W       = 19,
  parameter int DATA_W       = 8,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 16
) (
  input  logic             clock,
  input  logic             resetn,
  vga_fb_arbiter_if.slave  io_bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [ADDR_W-1:0] r_fa [FIFO_DEPTH];
  logic [DATA_W-1:0] r_fd [FIFO_DEPTH];
  logic [PW-1:0]     r_wp, r_rp;
  logic [CW-1:0]     r_cnt;

  logic [2:0]        r_pv, r_ps;
  logic [DATA_W-1:0] r_vdata;
  logic [ADDR_W-1:0] r_maddr;
  logic [DATA_W-1:0] r_mwdata;
  logic              r_mwe;

  logic w_empty, w_full, w_push, w_force;
  logic w_rgrant, w_wgrant, w_sub;

  assign w_empty  = (r_cnt == '0);
  assign w_full   = (r_cnt == DEPTH_C);
  assign w_push   = io_bus.cpu_wr_en && !w_full;
  assign w_wgrant = !w_empty && (w_force || !io_bus.vga_req);
  assign w_rgrant = io_bus.vga_req && !w_force;
  // A displaced read still flows down the pipe, flagged to reuse old pixel.
  assign w_sub    = io_bus.vga_req && w_force;

`ifdef FB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);
  logic [SW-1:0] r_starve;

  assign w_force = !w_empty && (r_starve == LIMIT_C);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_starve <= '0;
    end else if (w_force) begin
      r_starve <= '0;
    end else if (w_full && io_bus.vga_req) begin
      r_starve <= r_starve + SW'(1);
    end else begin
      r_starve <= '0;
    end
  end
`else
  // Guard disabled: the comparison is constant false, VGA always wins.
  assign w_force = (STARVE_LIMIT < 0);
`endif

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_fa[r_wp] <= io_bus.cpu_wr_addr;
      r_fd[r_wp] <= io_bus.cpu_wr_data;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push)   r_wp <= r_wp + PW'(1);
      if (w_wgrant) r_rp <= r_rp + PW'(1);
      unique case ({w_push, w_wgrant})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_maddr  <= '0;
      r_mwdata <= '0;
      r_mwe    <= 1'b0;
    end else begin
      unique case (1'b1)
        w_rgrant: begin
          r_maddr <= io_bus.vga_addr;
          r_mwe   <= 1'b0;
        end
        w_wgrant: begin
          r_maddr  <= r_fa[r_rp];
          r_mwdata <= r_fd[r_rp];
          r_mwe    <= 1'b1;
        end
        default: r_mwe <= 1'b0;
      endcase
    end
  end

  // Stage 1 = address on RAM, stage 2 = rdata back, stage 3 = output.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_pv    <= '0;
      r_ps    <= '0;
      r_vdata <= '0;
    end else begin
      r_pv <= {r_pv[1:0], io_bus.vga_req};
      r_ps <= {r_ps[1:0], w_sub};
      if (r_pv[1] && !r_ps[1]) r_vdata <= io_bus.mem_rdata;
    end
  end

  assign io_bus.vga_data     = r_vdata;
  assign io_bus.vga_valid    = r_pv[2];
  assign io_bus.cpu_wr_ready = (r_cnt < DEPTH_C);
  assign io_bus.mem_addr     = r_maddr;
  assign io_bus.mem_wdata    = r_mwdata;
  assign io_bus.mem_we       = r_mwe;
endmodule
